// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch, execute and downstream memory signals around mem_arbiter.
// The arbiter uses the slave view; the requesters and memory controller use the master view.
interface mem_arbiter_if #(
    parameter int unsigned M_WIDTH = 8
) ();
    logic               if_req;
    logic [M_WIDTH-1:0] if_addr;
    logic               if_abort;
    logic               if_ready;
    logic [M_WIDTH-1:0] if_data;

    logic               ex_req;
    logic               ex_we;
    logic [M_WIDTH-1:0] ex_addr;
    logic [M_WIDTH-1:0] ex_data_wr;
    logic [1:0]         ex_acc_width;
    logic               ex_ready;
    logic [M_WIDTH-1:0] ex_data_rd;

    logic               mem_req;
    logic               mem_we;
    logic [M_WIDTH-1:0] mem_addr;
    logic [M_WIDTH-1:0] mem_data_out;
    logic [1:0]         mem_acc_width;
    logic [M_WIDTH-1:0] mem_data_in;
    logic               mem_ready;

    modport slave (
        input  if_req, if_addr, if_abort,
        input  ex_req, ex_we, ex_addr, ex_data_wr, ex_acc_width,
        input  mem_data_in, mem_ready,
        output if_ready, if_data, ex_ready, ex_data_rd,
        output mem_req, mem_we, mem_addr, mem_data_out, mem_acc_width
    );

    modport master (
        output if_req, if_addr, if_abort,
        output ex_req, ex_we, ex_addr, ex_data_wr, ex_acc_width,
        output mem_data_in, mem_ready,
        input  if_ready, if_data, ex_ready, ex_data_rd,
        input  mem_req, mem_we, mem_addr, mem_data_out, mem_acc_width
    );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one external memory port between instruction fetch and the execute stage.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; default is execute-first.
module mem_arbiter #(
    parameter int unsigned M_WIDTH    = 8,
    parameter logic [1:0]  MEM_ACC_32 = 2'b10
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

    state_e             state_q, state_d;
    logic               owner_q, owner_d;  // 0 = fetch, 1 = execute
    logic               abort_q, abort_d;
    logic               grant_ex;

    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [M_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [M_WIDTH-1:0] mem_data_out_q, mem_data_out_d;
    logic [1:0]         mem_acc_width_q, mem_acc_width_d;
    logic               if_ready_q, if_ready_d;
    logic               ex_ready_q, ex_ready_d;
    logic [M_WIDTH-1:0] if_data_q, if_data_d;
    logic [M_WIDTH-1:0] ex_data_rd_q, ex_data_rd_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_ex_q, rr_ex_d;  // side favoured on the next contended grant

    always_comb begin
        rr_ex_d = rr_ex_q;
        if (bus.if_req && bus.ex_req) begin
            grant_ex = rr_ex_q;
        end else begin
            grant_ex = bus.ex_req;
        end
        if (state_q == StIdle && (bus.if_req || bus.ex_req)) begin
            rr_ex_d = ~grant_ex;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ex_q <= 1'b0;
        end else begin
            rr_ex_q <= rr_ex_d;
        end
    end
`else
    assign grant_ex = bus.ex_req;
`endif

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        abort_d         = abort_q;
        mem_req_d       = mem_req_q;
        mem_we_d        = mem_we_q;
        mem_addr_d      = mem_addr_q;
        mem_data_out_d  = mem_data_out_q;
        mem_acc_width_d = mem_acc_width_q;
        if_data_d       = if_data_q;
        ex_data_rd_d    = ex_data_rd_q;
        if_ready_d      = 1'b0;
        ex_ready_d      = 1'b0;

        case (state_q)
            StIdle: begin
                if (bus.if_req || bus.ex_req) begin
                    state_d   = StBusy;
                    owner_d   = grant_ex;
                    mem_req_d = 1'b1;
                    if (grant_ex) begin
                        mem_we_d        = bus.ex_we;
                        mem_addr_d      = bus.ex_addr;
                        mem_data_out_d  = bus.ex_data_wr;
                        mem_acc_width_d = bus.ex_acc_width;
                    end else begin
                        mem_we_d        = 1'b0;
                        mem_addr_d      = bus.if_addr;
                        mem_data_out_d  = '0;
                        mem_acc_width_d = MEM_ACC_32;
                        abort_d         = bus.if_abort;
                    end
                end
            end
            StBusy: begin
                if (!owner_q && bus.if_abort) begin
                    abort_d = 1'b1;
                end
                if (bus.mem_ready) begin
                    state_d   = StResp;
                    mem_req_d = 1'b0;
                    if (owner_q) begin
                        ex_data_rd_d = bus.mem_data_in;
                        ex_ready_d   = 1'b1;
                    end else if (!abort_d) begin
                        // A flushed fetch still finishes downstream but is never reported.
                        if_data_d  = bus.mem_data_in;
                        if_ready_d = 1'b1;
                    end
                end
            end
            StResp: begin
                // The ready pulse is already on the outputs; the flag is dropped entering idle.
                state_d = StIdle;
                abort_d = 1'b0;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            owner_q         <= 1'b0;
            abort_q         <= 1'b0;
            mem_req_q       <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_data_out_q  <= '0;
            mem_acc_width_q <= '0;
            if_ready_q      <= 1'b0;
            ex_ready_q      <= 1'b0;
            if_data_q       <= '0;
            ex_data_rd_q    <= '0;
        end else begin
            state_q         <= state_d;
            owner_q         <= owner_d;
            abort_q         <= abort_d;
            mem_req_q       <= mem_req_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_data_out_q  <= mem_data_out_d;
            mem_acc_width_q <= mem_acc_width_d;
            if_ready_q      <= if_ready_d;
            ex_ready_q      <= ex_ready_d;
            if_data_q       <= if_data_d;
            ex_data_rd_q    <= ex_data_rd_d;
        end
    end

    assign bus.mem_req       = mem_req_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_data_out  = mem_data_out_q;
    assign bus.mem_acc_width = mem_acc_width_q;
    assign bus.if_ready      = if_ready_q;
    assign bus.if_data       = if_data_q;
    assign bus.ex_ready      = ex_ready_q;
    assign bus.ex_data_rd    = ex_data_rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a transaction-level reference model.
// Build with ARB_ROUND_ROBIN_EN defined to exercise the alternating-grant arbitration.
module tb_mem_arbiter;

    localparam int unsigned W = 8;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit EX_FIRST = 1'b0;
`else
    localparam bit EX_FIRST = 1'b1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_arbiter_if #(.M_WIDTH(W)) bus ();

    mem_arbiter #(
        .M_WIDTH    (W),
        .MEM_ACC_32 (2'b10)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    bit           if_pend, ex_pend, in_txn, txn_owner, txn_abort;
    bit           exp_if_rdy, exp_ex_rdy, rr_fetch_first, abort_next;
    logic [W-1:0] exp_if_data, exp_ex_data, txn_addr, txn_wdata, txn_rdata;
    logic         txn_we;
    logic [1:0]   txn_acc;
    int           txn_cnt, txn_lat, lat_fix, gen_pct, abort_pct, force_rdata;
    int           cyc, n_if_rdy, n_ex_rdy;
    bit           grant_log[$];

    task automatic tick();
        bit owner;
        bit drop_if;
        bit drop_ex;
        @(posedge clk);
        #1;
        cyc++;
        check("if_ready", bus.if_ready, exp_if_rdy);
        check("ex_ready", bus.ex_ready, exp_ex_rdy);
        check("if_data", bus.if_data, exp_if_data);
        check("ex_data_rd", bus.ex_data_rd, exp_ex_data);
        if (bus.if_ready) n_if_rdy++;
        if (bus.ex_ready) n_ex_rdy++;
        exp_if_rdy    = 1'b0;
        exp_ex_rdy    = 1'b0;
        bus.if_abort  = 1'b0;
        bus.mem_ready = 1'b0;
        drop_if       = 1'b0;
        drop_ex       = 1'b0;
        if (bus.if_ready && if_pend) begin
            if_pend = 1'b0;
            drop_if = 1'b1;
        end
        if (bus.ex_ready && ex_pend) begin
            ex_pend = 1'b0;
            drop_ex = 1'b1;
        end

        if (bus.mem_req && !in_txn) begin
            // A grant happened at the edge just passed, on the requests sampled there.
            check("grant_has_req", bus.if_req | bus.ex_req, 1);
            if (bus.if_req && bus.ex_req) begin
`ifdef ARB_ROUND_ROBIN_EN
                owner = !rr_fetch_first;
`else
                owner = 1'b1;
`endif
            end else begin
                owner = bus.ex_req;
            end
            rr_fetch_first = owner;
            grant_log.push_back(owner);
            in_txn    = 1'b1;
            txn_owner = owner;
            txn_abort = 1'b0;
            txn_cnt   = 0;
            txn_lat   = (lat_fix >= 0) ? lat_fix : int'($urandom_range(3));
            txn_rdata = (force_rdata >= 0) ? W'(force_rdata) : W'($urandom);
            if (owner) begin
                txn_we    = bus.ex_we;
                txn_addr  = bus.ex_addr;
                txn_wdata = bus.ex_data_wr;
                txn_acc   = bus.ex_acc_width;
            end else begin
                txn_we    = 1'b0;
                txn_addr  = bus.if_addr;
                txn_wdata = '0;
                txn_acc   = 2'b10;
            end
        end

        if (in_txn) begin
            check("mem_req", bus.mem_req, 1);
            check("mem_we", bus.mem_we, txn_we);
            check("mem_addr", bus.mem_addr, txn_addr);
            check("mem_data_out", bus.mem_data_out, txn_wdata);
            check("mem_acc_width", bus.mem_acc_width, txn_acc);
            if (!txn_owner && if_pend && (abort_next || $urandom_range(99) < abort_pct)) begin
                bus.if_abort = 1'b1;
                txn_abort    = 1'b1;
                if_pend      = 1'b0;
                drop_if      = 1'b1;
                abort_next   = 1'b0;
            end else if (txn_owner && $urandom_range(99) < abort_pct) begin
                bus.if_abort = 1'b1;
            end
            if (txn_cnt == txn_lat) begin
                bus.mem_ready   = 1'b1;
                bus.mem_data_in = txn_rdata;
                in_txn          = 1'b0;
                if (txn_owner) begin
                    exp_ex_rdy  = 1'b1;
                    exp_ex_data = txn_rdata;
                end else if (!txn_abort) begin
                    exp_if_rdy  = 1'b1;
                    exp_if_data = txn_rdata;
                end
            end else begin
                bus.mem_data_in = W'($urandom);
            end
            txn_cnt++;
        end else begin
            check("mem_req_idle", bus.mem_req, 0);
        end

        if (!if_pend && !drop_if && gen_pct > 0 && $urandom_range(99) < gen_pct) begin
            if_pend     = 1'b1;
            bus.if_addr = W'($urandom);
        end
        if (!ex_pend && !drop_ex && gen_pct > 0 && $urandom_range(99) < gen_pct) begin
            ex_pend          = 1'b1;
            bus.ex_we        = 1'($urandom);
            bus.ex_addr      = W'($urandom);
            bus.ex_data_wr   = W'($urandom);
            bus.ex_acc_width = 2'($urandom_range(2));
        end
        bus.if_req = if_pend;
        bus.ex_req = ex_pend;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        if_pend       = 1'b0;
        ex_pend       = 1'b0;
        bus.if_req    = 1'b0;
        bus.ex_req    = 1'b0;
        bus.if_abort  = 1'b0;
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_data_out", bus.mem_data_out, 0);
        check("rst_mem_acc_width", bus.mem_acc_width, 0);
        check("rst_if_ready", bus.if_ready, 0);
        check("rst_ex_ready", bus.ex_ready, 0);
        check("rst_if_data", bus.if_data, 0);
        check("rst_ex_data_rd", bus.ex_data_rd, 0);
        in_txn         = 1'b0;
        exp_if_rdy     = 1'b0;
        exp_ex_rdy     = 1'b0;
        exp_if_data    = '0;
        exp_ex_data    = '0;
        rr_fetch_first = 1'b1;
        abort_next     = 1'b0;
        n_if_rdy       = 0;
        n_ex_rdy       = 0;
        grant_log.delete();
        rst_n = 1'b1;
    endtask

    task automatic raise_if(input logic [W-1:0] a);
        if_pend     = 1'b1;
        bus.if_addr = a;
        bus.if_req  = 1'b1;
    endtask

    task automatic raise_ex(input logic we, input logic [W-1:0] a, input logic [W-1:0] d,
                            input logic [1:0] acc);
        ex_pend          = 1'b1;
        bus.ex_we        = we;
        bus.ex_addr      = a;
        bus.ex_data_wr   = d;
        bus.ex_acc_width = acc;
        bus.ex_req       = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((if_pend || ex_pend || in_txn || exp_if_rdy || exp_ex_rdy) && n < 300) begin
            tick();
            n++;
        end
        check(tag, n < 300, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int hi;
        bus.if_req = 1'b0;       bus.if_addr = '0;     bus.if_abort = 1'b0;
        bus.ex_req = 1'b0;       bus.ex_we = 1'b0;     bus.ex_addr = '0;
        bus.ex_data_wr = '0;     bus.ex_acc_width = '0;
        bus.mem_data_in = '0;    bus.mem_ready = 1'b0;
        cyc = 0; gen_pct = 0; abort_pct = 0; lat_fix = 1; force_rdata = -1;
        do_reset();

        // Single fetch, memory answers one cycle after mem_req.
        force_rdata = 8'hA5;
        raise_if(8'h10);
        t0 = cyc;
        n  = 0;
        do begin tick(); n++; end while (!bus.if_ready && n < 20);
        check("fetch_latency", cyc - t0, 3);
        check("fetch_rdata", bus.if_data, 8'hA5);
        wait_idle("fetch_drain");

        // Store with four wait states.
        n_if_rdy = 0; n_ex_rdy = 0; lat_fix = 4; force_rdata = -1;
        raise_ex(1'b1, 8'h20, 8'h3C, 2'b10);
        n = 0; hi = 0;
        do begin tick(); n++; if (bus.mem_req) hi++; end while (!bus.ex_ready && n < 30);
        check("store_mem_req_cycles", hi, 5);
        wait_idle("store_drain");
        check("store_ex_pulses", n_ex_rdy, 1);
        check("store_if_pulses", n_if_rdy, 0);

        // Flushed fetch: transaction completes downstream, no ready, data kept.
        n_if_rdy = 0; lat_fix = 3; abort_next = 1'b1;
        raise_if(8'h44);
        wait_idle("abort_drain");
        check("abort_if_pulses", n_if_rdy, 0);
        check("abort_if_data_kept", bus.if_data, 8'hA5);
        force_rdata = 8'h5A;
        raise_if(8'h55);
        wait_idle("after_abort_drain");
        check("after_abort_if_pulses", n_if_rdy, 1);
        check("after_abort_if_data", bus.if_data, 8'h5A);

        // Simultaneous requests straight after reset.
        force_rdata = -1; lat_fix = -1;
        do_reset();
        raise_if(8'h31);
        raise_ex(1'b0, 8'h32, 8'h00, 2'b01);
        wait_idle("contend_drain");
        check("contend_grants", grant_log.size(), 2);
        check("contend_first", grant_log[0], EX_FIRST);
        check("contend_second", grant_log[1], !EX_FIRST);
        check("contend_if_pulses", n_if_rdy, 1);
        check("contend_ex_pulses", n_ex_rdy, 1);

        // Reset while the downstream port is busy.
        lat_fix = 6;
        raise_ex(1'b0, 8'h66, 8'h00, 2'b00);
        n = 0;
        do begin tick(); n++; end while (!bus.mem_req && n < 10);
        check("midop_busy", bus.mem_req, 1);
        tick();
        do_reset();
        lat_fix = -1;
        raise_ex(1'b1, 8'h77, 8'h99, 2'b01);
        wait_idle("midop_drain");
        check("midop_ex_pulses", n_ex_rdy, 1);
        check("midop_grant", grant_log[0], 1);

        // Random traffic with flushes and variable memory latency.
        gen_pct = 30; abort_pct = 10;
        for (int i = 0; i < 3000; i++) tick();
        gen_pct = 0; abort_pct = 0;
        wait_idle("random_drain");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
